// File: rtl/mini_src_datapath.sv
// Mini-SRC single-bus CPU datapath: register file, special registers, ALU,
// CON flip-flop and word-addressed RAM. All strobes come from outside.
// The RAM starts at all zeros.
module mini_src_datapath #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MEM_DEPTH = 512
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighin,
  input  logic        ZLowin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        OutPort,
  input  logic        Yin,
  input  logic        PCout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        ZHighout,
  input  logic        ZLowout,
  input  logic        InPort,
  input  logic        MDRout,
  input  logic        Cout,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        Read,
  input  logic        Write,
  input  logic        IncPC,
  input  logic        CON_In,
  input  logic [4:0]  OP,
  output logic        CON_Out,
  input  logic [15:0] enable_R,
  input  logic [15:0] select_R
);

  localparam int unsigned AW  = $clog2(MEM_DEPTH);
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [4:0] {
    ALU_AND  = 5'b00000,
    ALU_OR   = 5'b00001,
    ALU_ADD  = 5'b00010,
    ALU_SUB  = 5'b00011,
    ALU_SHR  = 5'b00100,
    ALU_SHRA = 5'b00101,
    ALU_SHL  = 5'b00110,
    ALU_ROR  = 5'b00111,
    ALU_ROL  = 5'b01000,
    ALU_MUL  = 5'b01001,
    ALU_DIV  = 5'b01010,
    ALU_NEG  = 5'b01011,
    ALU_NOT  = 5'b01100,
    ALU_INC  = 5'b01101
  } alu_op_e;

  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   pc, ir, hi, lo, y, mar, mdr, in_reg, out_reg;
  logic [2*WIDTH-1:0] z;
  logic [WIDTH-1:0]   gpr [16];
  logic               con;

  logic [WIDTH-1:0]   mem [MEM_DEPTH] = '{default: '0};

  logic [AW-1:0]      mem_addr;
  logic [WIDTH-1:0]   mem_rdata;
  logic [WIDTH-1:0]   c_sext;

  logic [3:0]         reg_idx;
  logic               reg_vld;
  logic [15:0]        reg_dec;
  logic [15:0]        gpr_wen;
  logic [15:0]        gpr_rsel;
  logic               ba_zero;
  logic [WIDTH-1:0]   gpr_bus;
  logic               gpr_found;

  logic [WIDTH-1:0]   alu_lo, alu_hi;
  logic [2*WIDTH-1:0] mul_a, mul_b, mul_p;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic [SHW-1:0]     sh;
  logic               cond;

  logic               unused_bits;

  assign mem_addr    = mar[AW-1:0];
  assign mem_rdata   = mem[mem_addr];
  assign c_sext      = {{(WIDTH-19){ir[18]}}, ir[18:0]};
  assign CON_Out     = con;
  assign unused_bits = ^{ir[WIDTH-1:27], mar[WIDTH-1:AW], out_reg};

  // Decode the IR register field selected by Gra/Grb/Grc into a one-hot.
  always_comb begin
    reg_idx = '0;
    reg_vld = 1'b0;
    reg_dec = '0;
    if (Gra) begin
      reg_idx = ir[26:23];
      reg_vld = 1'b1;
    end else if (Grb) begin
      reg_idx = ir[22:19];
      reg_vld = 1'b1;
    end else if (Grc) begin
      reg_idx = ir[18:15];
      reg_vld = 1'b1;
    end
    if (reg_vld) begin
      reg_dec[reg_idx] = 1'b1;
    end
  end

  assign gpr_wen  = (Rin ? reg_dec : '0) | enable_R;
  assign gpr_rsel = ((Rout | BAout) ? reg_dec : '0) | select_R;
  assign ba_zero  = BAout & reg_vld & (reg_idx == 4'd0);

  // GPR read port: lowest selected index wins; base-address use of R0 reads 0.
  always_comb begin
    gpr_bus   = '0;
    gpr_found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (gpr_rsel[i] && !gpr_found) begin
        gpr_bus   = gpr[i];
        gpr_found = 1'b1;
      end
    end
    if (gpr_rsel[0] && ba_zero) begin
      gpr_bus = '0;
    end
  end

  // Single shared bus: fixed-priority source mux, idle value 0.
  always_comb begin
    bus = '0;
    if (MDRout)         bus = mdr;
    else if (PCout)     bus = pc;
    else if (ZLowout)   bus = z[WIDTH-1:0];
    else if (ZHighout)  bus = z[2*WIDTH-1:WIDTH];
    else if (HIout)     bus = hi;
    else if (LOout)     bus = lo;
    else if (InPort)    bus = in_reg;
    else if (Cout)      bus = c_sext;
    else if (gpr_found) bus = gpr_bus;
  end

  assign sh    = bus[SHW-1:0];
  assign mul_a = {{WIDTH{y[WIDTH-1]}}, y};
  assign mul_b = {{WIDTH{bus[WIDTH-1]}}, bus};
  assign mul_p = mul_a * mul_b;
  assign rot_r = {y, y} >> sh;
  assign rot_l = {y, y} << sh;

  // ALU: A is Y, B is the bus; only MUL and DIV produce a nonzero upper half.
  always_comb begin
    alu_lo = bus;
    alu_hi = '0;
    case (alu_op_e'(OP))
      ALU_AND:  alu_lo = y & bus;
      ALU_OR:   alu_lo = y | bus;
      ALU_ADD:  alu_lo = y + bus;
      ALU_SUB:  alu_lo = y - bus;
      ALU_SHR:  alu_lo = y >> sh;
      ALU_SHRA: alu_lo = $unsigned($signed(y) >>> sh);
      ALU_SHL:  alu_lo = y << sh;
      ALU_ROR:  alu_lo = rot_r[WIDTH-1:0];
      ALU_ROL:  alu_lo = rot_l[2*WIDTH-1:WIDTH];
      ALU_MUL: begin
        alu_lo = mul_p[WIDTH-1:0];
        alu_hi = mul_p[2*WIDTH-1:WIDTH];
      end
      ALU_DIV: begin
        if (bus == '0) begin
          alu_lo = '0;
          alu_hi = y;
        end else begin
          alu_lo = $unsigned($signed(y) / $signed(bus));
          alu_hi = $unsigned($signed(y) % $signed(bus));
        end
      end
      ALU_NEG:  alu_lo = '0 - bus;
      ALU_NOT:  alu_lo = ~bus;
      ALU_INC:  alu_lo = bus + WIDTH'(1);
      default:  alu_lo = bus;
    endcase
  end

  // Branch condition evaluated on the bus according to IR[20:19].
  always_comb begin
    case (ir[20:19])
      2'b00:   cond = (bus == '0);
      2'b01:   cond = (bus != '0);
      2'b10:   cond = ~bus[WIDTH-1];
      default: cond = bus[WIDTH-1];
    endcase
  end

  // Register state: Clear overrides every load strobe.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      pc      <= '0;
      ir      <= '0;
      hi      <= '0;
      lo      <= '0;
      y       <= '0;
      z       <= '0;
      mar     <= '0;
      mdr     <= '0;
      in_reg  <= '0;
      out_reg <= '0;
      con     <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        gpr[i] <= '0;
      end
    end else begin
      if (IncPC)     pc <= pc + WIDTH'(1);
      else if (PCin) pc <= bus;
      if (IRin)    ir  <= bus;
      if (HIin)    hi  <= bus;
      if (LOin)    lo  <= bus;
      if (Yin)     y   <= bus;
      if (MARin)   mar <= bus;
      if (ZHighin) z[2*WIDTH-1:WIDTH] <= alu_hi;
      if (ZLowin)  z[WIDTH-1:0]       <= alu_lo;
      if (MDRin)   mdr <= Read ? mem_rdata : bus;
      if (OutPort) out_reg <= bus;
      if (CON_In)  con <= cond;
      for (int unsigned i = 0; i < 16; i++) begin
        if (gpr_wen[i]) gpr[i] <= bus;
      end
    end
  end

  // RAM write port from MDR; untouched by Clear.
  always_ff @(posedge Clock) begin
    if (Write) begin
      mem[mem_addr] <= mdr;
    end
  end

endmodule

// File: tb/tb_mini_src_datapath.sv
// Self-checking bench for mini_src_datapath. Constants are built inside the
// datapath with INC/ADD through the ALU, since the block has no data input.
module tb_mini_src_datapath;

    localparam logic [4:0] O_AND = 5'b00000, O_OR = 5'b00001, O_ADD = 5'b00010,
        O_SUB = 5'b00011, O_SHR = 5'b00100, O_SHRA = 5'b00101, O_SHL = 5'b00110,
        O_ROR = 5'b00111, O_ROL = 5'b01000, O_MUL = 5'b01001, O_DIV = 5'b01010,
        O_NEG = 5'b01011, O_NOT = 5'b01100, O_INC = 5'b01101, O_PASS = 5'b11111;

    logic Clock = 1'b0;
    logic Clear, PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin;
    logic PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In;
    logic [4:0]  OP;
    logic        CON_Out;
    logic [15:0] enable_R, select_R;

    int passes = 0;
    int checks = 0;

    logic [63:0] exp_q [$];
    string       name_q [$];

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] z;
    } alu_vec_t;

    alu_vec_t vecs [17];

    mini_src_datapath #(.WIDTH(32), .MEM_DEPTH(512)) dut (
        .Clock(Clock), .Clear(Clear), .PCin(PCin), .IRin(IRin), .HIin(HIin),
        .LOin(LOin), .ZHighin(ZHighin), .ZLowin(ZLowin), .MARin(MARin),
        .MDRin(MDRin), .OutPort(OutPort), .Yin(Yin), .PCout(PCout),
        .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout), .ZLowout(ZLowout),
        .InPort(InPort), .MDRout(MDRout), .Cout(Cout), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Read(Read),
        .Write(Write), .IncPC(IncPC), .CON_In(CON_In), .OP(OP),
        .CON_Out(CON_Out), .enable_R(enable_R), .select_R(select_R)
    );

    always #5 Clock = ~Clock;

    task automatic clr_strobes();
        Clear = 0; PCin = 0; IRin = 0; HIin = 0; LOin = 0; ZHighin = 0;
        ZLowin = 0; MARin = 0; MDRin = 0; OutPort = 0; Yin = 0; PCout = 0;
        HIout = 0; LOout = 0; ZHighout = 0; ZLowout = 0; InPort = 0;
        MDRout = 0; Cout = 0; Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0;
        BAout = 0; Read = 0; Write = 0; IncPC = 0; CON_In = 0; OP = O_AND;
        enable_R = '0; select_R = '0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        clr_strobes();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            passes++;
    endtask

    task automatic sb_check(input logic [63:0] act);
        logic [63:0] e;
        string n;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL scoreboard_empty: got %h, expected a queued value", act);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, act, e);
        end
    endtask

    // Leaves v in Z[31:0] (clobbers Y; Z[63:32] untouched).
    task automatic load_const(input logic [31:0] v);
        bit started = 0;
        ZLowin = 1; OP = O_PASS; step();
        for (int i = 31; i >= 0; i--) begin
            if (started) begin
                ZLowout = 1; Yin = 1; step();
                ZLowout = 1; OP = O_ADD; ZLowin = 1; step();
            end
            if (v[i]) begin
                ZLowout = 1; OP = O_INC; ZLowin = 1; step();
                started = 1;
            end
        end
    endtask

    initial begin
        logic [31:0] rv;
        logic        any_gpr;

        vecs[0]  = '{"and",    O_AND,  32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000};
        vecs[1]  = '{"or",     O_OR,   32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_FFF0FFF0};
        vecs[2]  = '{"add_wr", O_ADD,  32'hFFFFFFFF, 32'h00000002, 64'h00000000_00000001};
        vecs[3]  = '{"sub",    O_SUB,  32'h00000005, 32'h00000007, 64'h00000000_FFFFFFFE};
        vecs[4]  = '{"shr",    O_SHR,  32'h80000000, 32'h00000004, 64'h00000000_08000000};
        vecs[5]  = '{"shra",   O_SHRA, 32'h80000000, 32'h00000004, 64'h00000000_F8000000};
        vecs[6]  = '{"shl31",  O_SHL,  32'h00000001, 32'h0000001F, 64'h00000000_80000000};
        vecs[7]  = '{"shl33",  O_SHL,  32'h00000001, 32'h00000021, 64'h00000000_00000002};
        vecs[8]  = '{"ror",    O_ROR,  32'h00000001, 32'h00000001, 64'h00000000_80000000};
        vecs[9]  = '{"rol",    O_ROL,  32'h80000001, 32'h00000004, 64'h00000000_00000018};
        vecs[10] = '{"mul",    O_MUL,  32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA};
        vecs[11] = '{"div0",   O_DIV,  32'h00000007, 32'h00000000, 64'h00000007_00000000};
        vecs[12] = '{"divneg", O_DIV,  32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
        vecs[13] = '{"neg",    O_NEG,  32'h00000000, 32'h00000001, 64'h00000000_FFFFFFFF};
        vecs[14] = '{"not",    O_NOT,  32'h00000000, 32'h0F0F0F0F, 64'h00000000_F0F0F0F0};
        vecs[15] = '{"inc_wr", O_INC,  32'h00000000, 32'hFFFFFFFF, 64'h00000000_00000000};
        vecs[16] = '{"pass",   O_PASS, 32'h00000000, 32'h12345678, 64'h00000000_12345678};

        clr_strobes();
        Clear = 1;
        step();
        check("rst_pc", {32'h0, dut.pc}, 64'h0);
        check("rst_con", {63'h0, CON_Out}, 64'h0);

        // Random loads everywhere, then Clear asserted alongside loads.
        rv = $urandom | 32'h1;
        load_const(rv);
        ZLowout = 1; PCin = 1; IRin = 1; HIin = 1; LOin = 1; MARin = 1; MDRin = 1;
        OutPort = 1; Yin = 1; enable_R = 16'hFFFF; CON_In = 1; step();
        ZLowout = 1; PCin = 1; IRin = 1; HIin = 1; ZLowin = 1; ZHighin = 1;
        enable_R = 16'hFFFF; Clear = 1; step();
        check("clr_pc",  {32'h0, dut.pc},  64'h0);
        check("clr_ir",  {32'h0, dut.ir},  64'h0);
        check("clr_hi",  {32'h0, dut.hi},  64'h0);
        check("clr_lo",  {32'h0, dut.lo},  64'h0);
        check("clr_y",   {32'h0, dut.y},   64'h0);
        check("clr_z",   dut.z,            64'h0);
        check("clr_mar", {32'h0, dut.mar}, 64'h0);
        check("clr_mdr", {32'h0, dut.mdr}, 64'h0);
        check("clr_out", {32'h0, dut.out_reg}, 64'h0);
        check("clr_con", {63'h0, CON_Out}, 64'h0);
        any_gpr = 0;
        for (int i = 0; i < 16; i++) any_gpr |= |dut.gpr[i];
        check("clr_gpr", {63'h0, any_gpr}, 64'h0);
        check("clr_bus", {32'h0, dut.bus}, 64'h0);

        // ANDI R2, R3, 0x1000F from RAM[0].
        load_const(32'h0119000F);
        ZLowout = 1; MDRin = 1; step();
        Write = 1; step();
        load_const(32'h000000F5);
        ZLowout = 1; enable_R = 16'h0008; step();
        PCout = 1; MARin = 1; IncPC = 1; step();
        Read = 1; MDRin = 1; step();
        MDRout = 1; IRin = 1; step();
        Grb = 1; Rout = 1; Yin = 1; step();
        Cout = 1; OP = O_AND; ZLowin = 1; ZHighin = 1; step();
        ZLowout = 1; Gra = 1; Rin = 1; step();
        check("andi_ir", {32'h0, dut.ir}, 64'h0119000F);
        check("andi_r2", {32'h0, dut.gpr[2]}, 64'h5);
        check("andi_pc", {32'h0, dut.pc}, 64'h1);

        // ALU table through the scoreboard.
        for (int k = 0; k < 17; k++) begin
            load_const(vecs[k].b);
            ZLowout = 1; HIin = 1; step();
            load_const(vecs[k].a);
            ZLowout = 1; Yin = 1; step();
            HIout = 1; OP = vecs[k].op; ZLowin = 1; ZHighin = 1;
            exp_q.push_back(vecs[k].z);
            name_q.push_back({"alu_", vecs[k].name});
            step();
            sb_check(dut.z);
        end

        // Bus priority: Z = 0x1_00000002 built from 5 DIV 2.
        load_const(32'h2);
        ZLowout = 1; HIin = 1; step();
        load_const(32'h5);
        ZLowout = 1; Yin = 1; step();
        HIout = 1; OP = O_DIV; ZLowin = 1; ZHighin = 1; step();
        check("prio_z", dut.z, 64'h00000001_00000002);
        ZLowout = 1; ZHighout = 1; #1;
        check("prio_zlo_zhi", {32'h0, dut.bus}, 64'h2);
        clr_strobes(); MDRout = 1; PCout = 1; #1;
        check("prio_mdr_pc", {32'h0, dut.bus}, 64'h0119000F);
        clr_strobes(); HIout = 1; LOout = 1; #1;
        check("prio_hi_lo", {32'h0, dut.bus}, 64'h2);
        clr_strobes();

        // R0 base-address behaviour and direct select_R.
        load_const(32'h5);
        ZLowout = 1; enable_R = 16'h0001; step();
        IRin = 1; step();
        Gra = 1; BAout = 1; #1;
        check("baout_r0", {32'h0, dut.bus}, 64'h0);
        clr_strobes(); Gra = 1; Rout = 1; #1;
        check("rout_r0", {32'h0, dut.bus}, 64'h5);
        clr_strobes(); select_R = 16'h8008; #1;
        check("sel_lowest", {32'h0, dut.bus}, 64'hF5);
        clr_strobes();

        // Same-edge drive and load of Z.
        load_const(32'h10);
        ZLowout = 1; OP = O_INC; ZLowin = 1; #1;
        check("same_edge_bus", {32'h0, dut.bus}, 64'h10);
        step();
        check("same_edge_z", {32'h0, dut.z[31:0]}, 64'h11);

        // PC wrap and IncPC over PCin.
        load_const(32'hFFFFFFFF);
        ZLowout = 1; PCin = 1; step();
        check("pc_load", {32'h0, dut.pc}, 64'hFFFFFFFF);
        IncPC = 1; step();
        check("pc_wrap", {32'h0, dut.pc}, 64'h0);
        ZLowout = 1; PCin = 1; IncPC = 1; step();
        check("pc_inc_prio", {32'h0, dut.pc}, 64'h1);

        // Memory top word, aliasing past 0x1FF.
        load_const(32'h1FF);
        ZLowout = 1; MARin = 1; step();
        load_const(32'hDEADBEEF);
        ZLowout = 1; MDRin = 1; step();
        Write = 1; step();
        MDRin = 1; step();
        Read = 1; MDRin = 1;
        exp_q.push_back(64'hDEADBEEF); name_q.push_back("mem_1ff");
        step();
        sb_check({32'h0, dut.mdr});
        load_const(32'h200);
        ZLowout = 1; MARin = 1; step();
        Read = 1; MDRin = 1;
        exp_q.push_back(64'h0119000F); name_q.push_back("mem_alias_rd");
        step();
        sb_check({32'h0, dut.mdr});
        load_const(32'hCAFE0001);
        ZLowout = 1; MDRin = 1; step();
        Write = 1; step();
        MARin = 1; step();
        Read = 1; MDRin = 1;
        exp_q.push_back(64'hCAFE0001); name_q.push_back("mem_alias_wr");
        step();
        sb_check({32'h0, dut.mdr});

        // Branch conditions.
        load_const(32'h00180000);
        ZLowout = 1; IRin = 1; step();
        load_const(32'h80000000);
        ZLowout = 1; HIin = 1; step();
        HIout = 1; CON_In = 1; step();
        check("con_neg", {63'h0, CON_Out}, 64'h1);
        IRin = 1; step();
        load_const(32'h1);
        ZLowout = 1; CON_In = 1; step();
        check("con_zero", {63'h0, CON_Out}, 64'h0);
        load_const(32'h00080000);
        ZLowout = 1; IRin = 1; step();
        load_const(32'h1);
        ZLowout = 1; CON_In = 1; step();
        check("con_nonzero", {63'h0, CON_Out}, 64'h1);
        load_const(32'h00100000);
        ZLowout = 1; IRin = 1; step();
        HIout = 1; CON_In = 1; step();
        check("con_pos", {63'h0, CON_Out}, 64'h0);

        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
